ifid_hazard_ctrl: RTL

IFID_HAZARD_CTRL -- requirements
Module: ifid_hazard_ctrl

---
 rtl/ifid_hazard_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID hazard controller: decides PC/IF-ID/pipeline enables, flush and bubble
// for memory freezes, taken branches and load-use hazards.
module ifid_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rt,
  input  logic             Branch_Taken,
  input  logic             Mem_Busy,
  output logic             PCWrite,
  output logic             IFID_En,
  output logic             IFID_Read,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             Pipe_En,
  output logic [CNT_W-1:0] Stall_Count
);

  typedef enum logic [1:0] {START, RUN, FLUSH} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [3:0]       flush_cnt_reg, flush_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             load_use;

  assign load_use = EX_MemRead && (EX_rt != 5'd0) &&
                    ((EX_rt == ID_rs) || (ID_UsesRt && (EX_rt == ID_rt)));

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    PCWrite        = 1'b1;
    IFID_En        = 1'b1;
    IFID_Flush     = 1'b0;
    IDEX_Bubble    = 1'b0;
    Pipe_En        = 1'b1;
    // Reset overrides the freeze so START outputs are visible while it is held.
    if (Mem_Busy && !Reset) begin
      PCWrite = 1'b0;
      IFID_En = 1'b0;
      Pipe_En = 1'b0;
    end else begin
      case (state_reg)
        START: begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          state_next  = RUN;
        end
        RUN: begin
          if (Branch_Taken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next     = FLUSH;
              flush_cnt_next = FLUSH_INIT;
            end
          end else if (load_use) begin
            PCWrite     = 1'b0;
            IFID_En     = 1'b0;
            IDEX_Bubble = 1'b1;
          end
        end
        FLUSH: begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          if (flush_cnt_reg <= 4'd1) begin
            state_next     = RUN;
            flush_cnt_next = 4'd0;
          end else begin
            flush_cnt_next = flush_cnt_reg - 4'd1;
          end
        end
        default: state_next = START;
      endcase
    end
  end

  assign IFID_Read   = IFID_En && !IFID_Flush;
  assign Stall_Count = stall_cnt_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= START;
      flush_cnt_reg <= 4'd0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      if (!PCWrite && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
